// File: rtl/jtag_instruction_unit.sv
// JTAG instruction register with capture/shift/update stages, registered decode and sticky clamp-hold.
// Optional IR parity check enabled by defining JTAG_IR_PARITY_EN.
module jtag_instruction_unit #(
  parameter int                  IR_WIDTH    = 5,
  parameter bit                  ID_PRESENT  = 1'b1,
  parameter logic [IR_WIDTH-1:0] CAPTURE_PAT = '0
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                tlr_reset,
  input  logic                capture_ir,
  input  logic                shift_ir,
  input  logic                update_ir,
  input  logic                tdi,
  output logic                tdo_ir,
  output logic [IR_WIDTH-1:0] instruction,
  output logic                bsr_select,
  output logic                id_select,
  output logic                bypass_select,
  output logic                tmp_select,
  output logic                ahb_select,
  output logic                ahb_fifo_read_select,
  output logic                bsr_mode,
  output logic                clamp_active,
  output logic                clamp_hold_decode,
  output logic                clamp_release_decode,
  output logic                bypass_decode,
  output logic                ir_updated,
  output logic                parity_err
);

`ifdef JTAG_IR_PARITY_EN
  localparam int SR_W = IR_WIDTH + 1;
`else
  localparam int SR_W = IR_WIDTH;
`endif

  localparam logic [IR_WIDTH-1:0] OP_EXTEST        = IR_WIDTH'(0);
  localparam logic [IR_WIDTH-1:0] OP_PRELOAD       = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] OP_IDCODE        = IR_WIDTH'(3);
  localparam logic [IR_WIDTH-1:0] OP_CLAMP_HOLD    = IR_WIDTH'(4);
  localparam logic [IR_WIDTH-1:0] OP_CLAMP_RELEASE = IR_WIDTH'(5);
  localparam logic [IR_WIDTH-1:0] OP_TMP_STATUS    = IR_WIDTH'(6);
  localparam logic [IR_WIDTH-1:0] OP_AHB           = IR_WIDTH'(7);
  localparam logic [IR_WIDTH-1:0] OP_AHB_FIFO_READ = IR_WIDTH'(8);
  localparam logic [IR_WIDTH-1:0] OP_BYPASS        = '1;
  localparam logic [IR_WIDTH-1:0] RESET_INSTR      = ID_PRESENT ? OP_IDCODE : OP_BYPASS;

  logic [SR_W-1:0]     sr;
  logic [SR_W-1:0]     cap_val;
  logic                parity_ok;
  logic [IR_WIDTH-1:0] upd_instr;
  logic                parity_err_q;

  // Capture value: low two bits fixed at 01, parity slot (if present) loads 1.
  always_comb begin
    cap_val                 = '0;
    cap_val[IR_WIDTH-1:0]   = {CAPTURE_PAT[IR_WIDTH-1:2], 2'b01};
`ifdef JTAG_IR_PARITY_EN
    cap_val[SR_W-1]         = 1'b1;
`endif
  end

  always_comb begin
`ifdef JTAG_IR_PARITY_EN
    parity_ok = ~(^sr);
`else
    parity_ok = 1'b1;
`endif
    upd_instr = parity_ok ? sr[IR_WIDTH-1:0] : OP_BYPASS;
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      sr                   <= '0;
      instruction          <= RESET_INSTR;
      clamp_active         <= 1'b0;
      parity_err_q         <= 1'b0;
      ir_updated           <= 1'b0;
      clamp_hold_decode    <= 1'b0;
      clamp_release_decode <= 1'b0;
      bypass_decode        <= 1'b0;
    end else begin
      ir_updated           <= 1'b0;
      clamp_hold_decode    <= 1'b0;
      clamp_release_decode <= 1'b0;
      bypass_decode        <= 1'b0;
      if (tlr_reset) begin
        instruction  <= RESET_INSTR;
        clamp_active <= 1'b0;
        parity_err_q <= 1'b0;
      end else if (capture_ir) begin
        sr <= cap_val;
      end else if (shift_ir) begin
        sr <= {tdi, sr[SR_W-1:1]};
      end else if (update_ir) begin
        instruction          <= upd_instr;
        ir_updated           <= 1'b1;
        parity_err_q         <= ~parity_ok;
        clamp_hold_decode    <= (upd_instr == OP_CLAMP_HOLD);
        clamp_release_decode <= (upd_instr == OP_CLAMP_RELEASE);
        // Everything above the highest defined opcode selects BYPASS.
        bypass_decode        <= (upd_instr > OP_AHB_FIFO_READ);
        if (upd_instr == OP_CLAMP_HOLD)
          clamp_active <= 1'b1;
        else if (upd_instr == OP_CLAMP_RELEASE)
          clamp_active <= 1'b0;
      end
    end
  end

`ifdef JTAG_IR_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign tdo_ir = sr[0];

  always_comb begin
    bsr_select           = 1'b0;
    id_select            = 1'b0;
    bypass_select        = 1'b0;
    tmp_select           = 1'b0;
    ahb_select           = 1'b0;
    ahb_fifo_read_select = 1'b0;
    if (instruction <= OP_PRELOAD)
      bsr_select = 1'b1;
    else if (instruction == OP_IDCODE)
      id_select = 1'b1;
    else if (instruction == OP_TMP_STATUS)
      tmp_select = 1'b1;
    else if (instruction == OP_AHB)
      ahb_select = 1'b1;
    else if (instruction == OP_AHB_FIFO_READ)
      ahb_fifo_read_select = 1'b1;
    else
      bypass_select = 1'b1;
    bsr_mode = (instruction == OP_EXTEST) | clamp_active;
  end

endmodule

// File: tb/tb_jtag_instruction_unit.sv
// Self-checking bench for jtag_instruction_unit: directed test-plan steps followed by random
// TAP control activity, all checked against a cycle model built from the opcode table.
module tb_jtag_instruction_unit;

  localparam int IRW = 5;
`ifdef JTAG_IR_PARITY_EN
  localparam int SRW = IRW + 1;
`else
  localparam int SRW = IRW;
`endif

  logic TCK = 1'b0;
  logic TRST = 1'b0;
  logic tlr_reset = 1'b0, capture_ir = 1'b0, shift_ir = 1'b0, update_ir = 1'b0, tdi = 1'b0;
  logic tdo_ir;
  logic [IRW-1:0] instruction;
  logic bsr_select, id_select, bypass_select, tmp_select, ahb_select, ahb_fifo_read_select;
  logic bsr_mode, clamp_active, clamp_hold_decode, clamp_release_decode, bypass_decode;
  logic ir_updated, parity_err;

  jtag_instruction_unit #(.IR_WIDTH(IRW), .ID_PRESENT(1'b1)) dut (
    .TCK(TCK), .TRST(TRST), .tlr_reset(tlr_reset), .capture_ir(capture_ir),
    .shift_ir(shift_ir), .update_ir(update_ir), .tdi(tdi), .tdo_ir(tdo_ir),
    .instruction(instruction), .bsr_select(bsr_select), .id_select(id_select),
    .bypass_select(bypass_select), .tmp_select(tmp_select), .ahb_select(ahb_select),
    .ahb_fifo_read_select(ahb_fifo_read_select), .bsr_mode(bsr_mode),
    .clamp_active(clamp_active), .clamp_hold_decode(clamp_hold_decode),
    .clamp_release_decode(clamp_release_decode), .bypass_decode(bypass_decode),
    .ir_updated(ir_updated), .parity_err(parity_err)
  );

  // Clock
  always #5 TCK = ~TCK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [SRW-1:0] m_sr;
  int             m_instr;
  bit             m_clamp, m_perr, m_upd, m_hold, m_rel, m_byp;

  function automatic logic [5:0] exp_sel(input int op);
    // {bsr, id, bypass, tmp, ahb, ahb_fifo_read}
    if (op >= 0 && op <= 2) return 6'b100000;
    if (op == 3)            return 6'b010000;
    if (op == 6)            return 6'b000100;
    if (op == 7)            return 6'b000010;
    if (op == 8)            return 6'b000001;
    return 6'b001000;
  endfunction

  function automatic logic [SRW-1:0] good_word(input logic [IRW-1:0] v);
`ifdef JTAG_IR_PARITY_EN
    return {^v, v};
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ":tdo"}, 32'(tdo_ir), 32'(m_sr[0]));
    check({tag, ":instr"}, 32'(instruction), 32'(m_instr));
    check({tag, ":sel"}, 32'({bsr_select, id_select, bypass_select, tmp_select, ahb_select,
                              ahb_fifo_read_select}), 32'(exp_sel(m_instr)));
    check({tag, ":bsr_mode"}, 32'(bsr_mode), 32'((m_instr == 0) || m_clamp));
    check({tag, ":clamp"}, 32'(clamp_active), 32'(m_clamp));
    check({tag, ":strobes"}, 32'({ir_updated, clamp_hold_decode, clamp_release_decode, bypass_decode}),
          32'({m_upd, m_hold, m_rel, m_byp}));
    check({tag, ":perr"}, 32'(parity_err), 32'(m_perr));
  endtask

  task automatic model_reset();
    m_sr = '0; m_instr = 3; m_clamp = 0; m_perr = 0;
    m_upd = 0; m_hold = 0; m_rel = 0; m_byp = 0;
  endtask

  // One TCK cycle: drive controls, advance the model by the priority rules, check after the edge.
  task automatic step(input string tag, input bit tlr, input bit cap, input bit sh,
                      input bit upd, input bit din);
    bit ok;
    int v;
    tlr_reset = tlr; capture_ir = cap; shift_ir = sh; update_ir = upd; tdi = din;
    m_upd = 0; m_hold = 0; m_rel = 0; m_byp = 0;
    if (tlr) begin
      m_instr = 3; m_clamp = 0; m_perr = 0;
    end else if (cap) begin
      m_sr = '0;
      m_sr[0] = 1'b1;
`ifdef JTAG_IR_PARITY_EN
      m_sr[SRW-1] = 1'b1;
`endif
    end else if (sh) begin
      m_sr = (m_sr >> 1) | (SRW'(din) << (SRW - 1));
    end else if (upd) begin
`ifdef JTAG_IR_PARITY_EN
      ok = ($countones(m_sr) % 2) == 0;
`else
      ok = 1;
`endif
      v = int'(m_sr[IRW-1:0]);
      m_upd = 1;
      if (!ok) begin
        m_instr = (1 << IRW) - 1; m_perr = 1; m_byp = 1;
      end else begin
        m_instr = v; m_perr = 0;
        m_hold = (v == 4); m_rel = (v == 5); m_byp = (v > 8);
        if (v == 4) m_clamp = 1;
        if (v == 5) m_clamp = 0;
      end
    end
    @(posedge TCK);
    #1;
    check_all(tag);
  endtask

  task automatic load_ir(input string tag, input logic [SRW-1:0] w);
    step({tag, ":cap"}, 0, 1, 0, 0, 0);
    for (int i = 0; i < SRW; i++) step({tag, ":shift"}, 0, 0, 1, 0, w[i]);
    step({tag, ":upd"}, 0, 0, 0, 1, 0);
    step({tag, ":idle"}, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [SRW-1:0] w;
    logic [IRW-1:0] op;
    model_reset();
    repeat (2) @(posedge TCK);
    @(negedge TCK);
    TRST = 1'b1;
    step("reset_idle", 0, 0, 0, 0, 0);
    check("reset_id_select", 32'(id_select), 32'd1);

    // Capture then shift out the 01 pattern while shifting in EXTEST
    load_ir("extest", good_word(5'h00));
    check("extest_bsr_select", 32'(bsr_select), 32'd1);
    load_ir("clamp_hold", good_word(5'h04));
    load_ir("ahb_clamped", good_word(5'h07));
    check("ahb_clamped_bsr_mode", 32'(bsr_mode), 32'd1);
    load_ir("clamp_release", good_word(5'h05));
    load_ir("undefined", good_word(5'h0C));
    load_ir("clamp_again", good_word(5'h04));

    // TLR beats update in the same cycle; no strobes
    step("pre_tlr_cap", 0, 1, 0, 0, 0);
    for (int i = 0; i < SRW; i++) step("pre_tlr_shift", 0, 0, 1, 0, good_word(5'h05)[i]);
    step("tlr_and_upd", 1, 0, 0, 1, 0);
    check("tlr_instr_idcode", 32'(instruction), 32'h3);

`ifdef JTAG_IR_PARITY_EN
    load_ir("parity_bad", {1'b0, 5'h01});
    check("parity_bad_instr", 32'(instruction), 32'h1F);
    load_ir("parity_good", {1'b1, 5'h01});
    check("parity_good_perr", 32'(parity_err), 32'd0);
`endif

    // Asynchronous TRST in the middle of a shift
    step("async_cap", 0, 1, 0, 0, 0);
    step("async_shift", 0, 0, 1, 0, 1);
    step("async_shift", 0, 0, 1, 0, 1);
    #3;
    TRST = 1'b0;
    #1;
    model_reset();
    check_all("async_trst");
    shift_ir = 1'b0;
    @(negedge TCK);
    TRST = 1'b1;
    step("after_trst", 0, 0, 0, 0, 0);

    // Random full instruction loads, some with corrupted parity
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 11))
        9:       op = IRW'($urandom);
        10:      op = '1;
        11:      op = IRW'($urandom_range(9, 30));
        default: op = IRW'($urandom_range(0, 8));
      endcase
      w = good_word(op);
`ifdef JTAG_IR_PARITY_EN
      if ($urandom_range(0, 3) == 0) w[SRW-1] = ~w[SRW-1];
`endif
      load_ir("rand_load", w);
      if ($urandom_range(0, 7) == 0) step("rand_tlr", 1, 0, 0, $urandom_range(0, 1) == 1, 0);
    end

    // Random overlapping control inputs exercise the priority order
    for (int n = 0; n < 60; n++) begin
      step("rand_ctrl", $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
